// File: rtl/column_drawer.sv
// column_drawer: renders one 160x120 view column (ceiling, wall, floor) into the VGA plot interface, one pixel per clock.
module column_drawer #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter logic [2:0] CEIL_COLOUR = 3'b000,
   parameter logic [2:0] FLOOR_COLOUR = 3'b111
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] col_x,
   input  logic [6:0] wall_height,
   input  logic [2:0] wall_colour,
   output logic       busy,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_write
);
   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
   localparam logic [6:0] H = SCREEN_H[6:0];
   localparam logic [8:0] W = SCREEN_W[8:0];
   state_t state_q, state_d;
   logic [7:0] x_q, x_d, vga_x_q, vga_x_d;
   logic [6:0] y_q, y_d, top_q, top_d, bot_q, bot_d, vga_y_q, vga_y_d;
   logic [2:0] wc_q, wc_d, vga_colour_q, vga_colour_d;
   logic busy_q, busy_d, done_q, done_d, vga_write_q, vga_write_d;
   logic [6:0] h_in, top_in, bot_in;
   function automatic logic [2:0] pick(input logic [6:0] y, input logic [6:0] t, input logic [6:0] b, input logic [2:0] w);
      return (y < t) ? CEIL_COLOUR : ((y < b) ? w : FLOOR_COLOUR);
   endfunction
   // The first pixel is issued on the accepting edge, so y_q always points at the next row to plot.
   always_comb begin
      h_in = (wall_height > H) ? H : wall_height;
      top_in = (H - h_in) >> 1;
      bot_in = top_in + h_in;
      state_d = state_q;
      x_d = x_q;
      y_d = y_q;
      top_d = top_q;
      bot_d = bot_q;
      wc_d = wc_q;
      busy_d = 1'b0;
      done_d = 1'b0;
      vga_write_d = 1'b0;
      vga_x_d = vga_x_q;
      vga_y_d = vga_y_q;
      vga_colour_d = vga_colour_q;
      case (state_q)
         IDLE: if (start) begin
            x_d = col_x;
            top_d = top_in;
            bot_d = bot_in;
            wc_d = wall_colour;
            busy_d = 1'b1;
            if ({1'b0, col_x} >= W) begin
               state_d = DONE;
               done_d = 1'b1;
            end else begin
               state_d = DRAW;
               y_d = 7'd1;
               vga_write_d = 1'b1;
               vga_x_d = col_x;
               vga_y_d = 7'd0;
               vga_colour_d = pick(7'd0, top_in, bot_in, wall_colour);
            end
         end
         DRAW: begin
            busy_d = 1'b1;
            if (y_q == H) begin
               state_d = DONE;
               done_d = 1'b1;
            end else begin
               y_d = y_q + 7'd1;
               vga_write_d = 1'b1;
               vga_x_d = x_q;
               vga_y_d = y_q;
               vga_colour_d = pick(y_q, top_q, bot_q, wc_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         x_q <= '0;
         y_q <= '0;
         top_q <= '0;
         bot_q <= '0;
         wc_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         vga_write_q <= 1'b0;
         vga_x_q <= '0;
         vga_y_q <= '0;
         vga_colour_q <= '0;
      end else begin
         state_q <= state_d;
         x_q <= x_d;
         y_q <= y_d;
         top_q <= top_d;
         bot_q <= bot_d;
         wc_q <= wc_d;
         busy_q <= busy_d;
         done_q <= done_d;
         vga_write_q <= vga_write_d;
         vga_x_q <= vga_x_d;
         vga_y_q <= vga_y_d;
         vga_colour_q <= vga_colour_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign vga_write = vga_write_q;
   assign vga_x = vga_x_q;
   assign vga_y = vga_y_q;
   assign vga_colour = vga_colour_q;
endmodule

// File: tb/tb_column_drawer.sv
// tb_column_drawer: randomized and directed column checks against an arithmetic model of the column layout.
module tb_column_drawer;
   logic clock = 1'b0;
   logic reset, start;
   logic [7:0] col_x;
   logic [6:0] wall_height;
   logic [2:0] wall_colour;
   logic busy, done, vga_write;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   int n_checks = 0;
   int n_fail = 0;
   logic [20:0] obs [1:122];
   column_drawer dut (
      .clock(clock), .reset(reset), .start(start), .col_x(col_x),
      .wall_height(wall_height), .wall_colour(wall_colour), .busy(busy), .done(done),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write)
   );
   always #5 clock = ~clock;
   function automatic logic [2:0] model_colour(input int y, input int wh, input logic [2:0] c);
      int h, top;
      h = (wh > 120) ? 120 : wh;
      top = (120 - h) / 2;
      return (y < top) ? 3'b000 : ((y < top + h) ? c : 3'b111);
   endfunction
   // Records {write, done, busy, x, y, colour} for the 122 cycles after the start edge; pixel fields masked when not writing.
   task automatic run_column(input logic [7:0] x, input int wh, input logic [2:0] c, input bit hold);
      logic [6:0] whv;
      whv = wh[6:0];
      col_x = x;
      wall_height = whv;
      wall_colour = c;
      start = 1'b1;
      @(posedge clock);
      #1 if (!hold) start = 1'b0;
      for (int k = 1; k <= 122; k++) begin
         @(negedge clock);
         obs[k] = {vga_write, done, busy, vga_write ? {vga_x, vga_y, vga_colour} : 18'h0};
      end
      start = 1'b0;
   endtask
   task automatic test_reset;
      int wr, dn;
      reset = 1'b1;
      start = 1'b1;
      col_x = 8'd10;
      wall_height = 7'd51;
      wall_colour = 3'b100;
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         @(negedge clock);
         n_checks++;
         if ({busy, done, vga_write, vga_x, vga_y, vga_colour} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, {busy, done, vga_write, vga_x, vga_y, vga_colour});
         end
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({busy, done, vga_write} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle: got busy/done/write %b expected 000", {busy, done, vga_write});
      end
      run_column(8'd10, 51, 3'b100, 1'b0);
      wr = 0;
      dn = 0;
      for (int k = 1; k <= 122; k++) begin
         wr += int'(obs[k][20]);
         dn += (obs[k][19] === 1'b1 && k == 121) ? 1 : 0;
      end
      n_checks++;
      if (wr != 120 || dn != 1) begin
         n_fail++;
         $display("FAIL reset_then_start: got %0d writes, done_at_121=%0d expected 120 writes and 1", wr, dn);
      end
   endtask
   task automatic test_columns;
      int xs [4] = '{10, 159, 20, 77};
      int hs [4] = '{51, 127, 0, 51};
      logic [2:0] cs [4] = '{3'b100, 3'b010, 3'b101, 3'b110};
      logic [7:0] x;
      logic [6:0] yy;
      logic [2:0] c;
      logic [20:0] exp_v;
      int wh;
      for (int i = 0; i < 16; i++) begin
         x = (i < 4) ? xs[i][7:0] : 8'($urandom_range(0, 159));
         wh = (i < 4) ? hs[i] : int'($urandom_range(0, 127));
         c = (i < 4) ? cs[i] : 3'($urandom_range(0, 7));
         run_column(x, wh, c, i == 3);
         for (int k = 1; k <= 122; k++) begin
            yy = 7'(k - 1);
            exp_v = (k <= 120) ? {3'b101, x, yy, model_colour(k - 1, wh, c)} : ((k == 121) ? {3'b011, 18'h0} : 21'h0);
            n_checks++;
            if (obs[k] !== exp_v) begin
               n_fail++;
               $display("FAIL column case %0d (x=%0d h=%0d c=%b) cycle %0d: got %h expected %h", i, x, wh, c, k, obs[k], exp_v);
            end
         end
      end
   endtask
   task automatic test_out_of_range;
      logic [7:0] x;
      logic [20:0] exp_v;
      for (int i = 0; i < 4; i++) begin
         x = (i == 0) ? 8'd160 : 8'($urandom_range(161, 255));
         run_column(x, int'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b0);
         for (int k = 1; k <= 122; k++) begin
            exp_v = (k == 1) ? {3'b011, 18'h0} : 21'h0;
            n_checks++;
            if (obs[k] !== exp_v) begin
               n_fail++;
               $display("FAIL out_of_range x=%0d cycle %0d: got %h expected %h", x, k, obs[k], exp_v);
            end
         end
      end
   endtask
   task automatic test_reset_mid_column;
      bit found;
      int wr, dn;
      col_x = 8'd42;
      wall_height = 7'd80;
      wall_colour = 3'b011;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 130 && !found; k++) begin
         @(negedge clock);
         found = (vga_write === 1'b1 && vga_y === 7'd50);
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL mid_reset_reach_y50: got no write at y=50 within 130 cycles, expected one");
      end
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({vga_write, done, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_reset_stop: got write/done/busy %b expected 000", {vga_write, done, busy});
      end
      reset = 1'b0;
      wr = 0;
      dn = 0;
      for (int k = 0; k < 130; k++) begin
         @(negedge clock);
         wr += (vga_write !== 1'b0) ? 1 : 0;
         dn += (done !== 1'b0) ? 1 : 0;
      end
      n_checks++;
      if (wr != 0 || dn != 0) begin
         n_fail++;
         $display("FAIL mid_reset_quiet: got %0d writes %0d done expected 0 and 0", wr, dn);
      end
      run_column(8'd42, 80, 3'b011, 1'b0);
      wr = 0;
      for (int k = 1; k <= 120; k++) wr += (obs[k] === {3'b101, 8'd42, 7'(k - 1), model_colour(k - 1, 80, 3'b011)}) ? 1 : 0;
      n_checks++;
      if (wr != 120 || obs[121] !== {3'b011, 18'h0}) begin
         n_fail++;
         $display("FAIL mid_reset_restart: got %0d correct pixels done_cycle=%h expected 120 and %h", wr, obs[121], {3'b011, 18'h0});
      end
   endtask
   initial begin
      test_reset;
      test_columns;
      test_out_of_range;
      test_reset_mid_column;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
